rs_sched_buf: RTL

- Parametrised successor to the reservation-station buffer: an age-ordered scheduler with DEPTH entries, NIN insert ports and NOUT issue ports.
- Tracks operand A/B readiness through tag wakeup and applies per-thread flush and a stall.
- Issues the oldest ready entry per functional-unit port.
- Payload lives in an external RAM indexed by slot number. This block holds control state only.

---
 rtl/rs_pkg.sv | 39 +++
 rtl/rs_age_pick.sv | 26 ++
 rtl/rs_sched_buf.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared types and helpers for the age-ordered reservation-station scheduler.
// Entry control state and the oldest-request picker used by every issue port.
package rs_pkg;

    localparam int RS_DEPTH = 8;
    localparam int RS_NOUT  = 4;
    localparam int RS_TAGW  = 6;

    typedef struct packed {
        logic               valid;
        logic               needA;
        logic               needB;
        logic [RS_TAGW-1:0] tagA;
        logic [RS_TAGW-1:0] tagB;
        logic [RS_NOUT-1:0] port;
        logic               thread;
    } rs_entry_t;

    // age[i][j] = 1 means entry i is older than entry j; the winner beats every other requester
    function automatic logic [RS_DEPTH-1:0] oldest_of(
        input logic [RS_DEPTH-1:0]               req,
        input logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age
    );
        logic [RS_DEPTH-1:0] grant;
        logic                win;
        grant = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            win = req[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && req[j] && !age[i][j]) begin
                    win = 1'b0;
                end
            end
            grant[i] = win;
        end
        return grant;
    endfunction

endpackage

// File: rtl/rs_age_pick.sv
// Picks the oldest requesting entry by age matrix; returns one-hot grant and encoded slot.
module rs_age_pick
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int SLOTW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            i_req,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
    output logic [DEPTH-1:0]            o_grant,
    output logic [SLOTW-1:0]            o_slot,
    output logic                        o_any
);

    always_comb begin
        o_grant = oldest_of(i_req, i_age);
        o_slot  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (o_grant[i]) begin
                o_slot = SLOTW'(i);
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/rs_sched_buf.sv
// Age-ordered scheduler: tag wakeup, per-thread flush, oldest-ready issue per FU port.
// Holds control state only; payload lives in an external RAM indexed by slot.
module rs_sched_buf
    import rs_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NIN   = 3,
    parameter int NOUT  = 4,
    parameter int NWK   = 4,
    parameter int TAGW  = 6,
    parameter int SLOTW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush_en,
    input  logic                  flush_thread,
    input  logic [NIN-1:0]        ins_vld,
    input  logic [NIN-1:0]        ins_needA,
    input  logic [NIN-1:0]        ins_needB,
    input  logic [NIN*TAGW-1:0]   ins_tagA,
    input  logic [NIN*TAGW-1:0]   ins_tagB,
    input  logic [NIN*NOUT-1:0]   ins_port,
    input  logic [NIN-1:0]        ins_thread,
    output logic [NIN*SLOTW-1:0]  ins_slot,
    output logic                  can_accept,
    output logic [SLOTW:0]        free_cnt,
    input  logic [NWK-1:0]        wk_vld,
    input  logic [NWK*TAGW-1:0]   wk_tag,
    input  logic [NOUT-1:0]       iss_rdy,
    output logic [NOUT-1:0]       iss_vld,
    output logic [NOUT*SLOTW-1:0] iss_slot,
    output logic [NOUT-1:0]       iss_thread
);

    rs_entry_t                   r_ent [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] r_age;
    logic [SLOTW:0]              r_free_cnt;
    logic                        r_can_accept;

    rs_entry_t                   w_ent_nxt [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] w_age_nxt;
    logic [SLOTW:0]              w_free_nxt;
    logic [DEPTH-1:0]            w_ready;
    logic [NOUT-1:0][DEPTH-1:0]  w_portmask;
    logic [NOUT-1:0][DEPTH-1:0]  w_fire;
    logic [DEPTH-1:0]            w_dealloc;
    logic [DEPTH-1:0]            w_taken_ins;
    logic [NIN-1:0]              w_ins_do;
    logic [DEPTH-1:0]            w_new;
    logic [2:0]                  w_rank [DEPTH];

    function automatic logic wk_hit(
        input logic [TAGW-1:0]     tag,
        input logic [NWK-1:0]      vld,
        input logic [NWK*TAGW-1:0] tags
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NWK; w++) begin
            if (vld[w] && tags[w*TAGW +: TAGW] == tag) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign free_cnt   = r_free_cnt;
    assign can_accept = r_can_accept;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_ent[i].valid & ~r_ent[i].needA & ~r_ent[i].needB;
            for (int k = 0; k < NOUT; k++) begin
                w_portmask[k][i] = r_ent[i].port[k];
            end
        end
    end

    // Issue ports are chained: each port only sees entries not granted to a lower port.
    for (genvar k = 0; k < NOUT; k++) begin : g_port
        logic [DEPTH-1:0] w_prev;
        logic [DEPTH-1:0] w_req;
        logic [DEPTH-1:0] w_grant;
        logic [SLOTW-1:0] w_slot;
        logic             w_any;

        if (k == 0) begin : g_head
            assign w_prev = '0;
        end else begin : g_tail
            assign w_prev = g_port[k-1].w_prev | g_port[k-1].w_grant;
        end

        assign w_req = w_ready & w_portmask[k] & ~w_prev;

        rs_age_pick #(
            .DEPTH (DEPTH),
            .SLOTW (SLOTW)
        ) u_pick (
            .i_req   (w_req),
            .i_age   (r_age),
            .o_grant (w_grant),
            .o_slot  (w_slot),
            .o_any   (w_any)
        );

        assign iss_vld[k]                  = w_any & ~stall;
        assign iss_slot[k*SLOTW +: SLOTW]  = w_slot;
        assign iss_thread[k]               = r_ent[w_slot].thread;
        assign w_fire[k]                   = w_grant & {DEPTH{iss_vld[k] & iss_rdy[k]}};
    end

    always_comb begin
        w_dealloc = '0;
        for (int k = 0; k < NOUT; k++) begin
            w_dealloc = w_dealloc | w_fire[k];
        end
    end

    // Allocation sees only slots free at the start of the cycle; same-cycle deallocs wait a cycle.
    always_comb begin
        logic             found;
        logic [SLOTW-1:0] sl;
        w_taken_ins = '0;
        ins_slot    = '0;
        w_ins_do    = '0;
        for (int p = 0; p < NIN; p++) begin
            found = 1'b0;
            sl    = '0;
            for (int s = 0; s < DEPTH; s++) begin
                if (!found && !r_ent[s].valid && !w_taken_ins[s]) begin
                    found = 1'b1;
                    sl    = SLOTW'(s);
                end
            end
            ins_slot[p*SLOTW +: SLOTW] = sl;
            if (ins_vld[p] && found) begin
                w_taken_ins[sl] = 1'b1;
            end
            w_ins_do[p] = ins_vld[p] && found && r_can_accept &&
                          !(flush_en && ins_thread[p] == flush_thread);
        end
    end

    always_comb begin
        logic [SLOTW-1:0] s;
        int               n_valid;
        w_ent_nxt = r_ent;
        w_age_nxt = r_age;
        w_new     = '0;
        s         = '0;
        n_valid   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rank[i] = '0;
            if (w_dealloc[i] || (flush_en && r_ent[i].thread == flush_thread)) begin
                w_ent_nxt[i].valid = 1'b0;
            end
            if (wk_hit(r_ent[i].tagA, wk_vld, wk_tag)) begin
                w_ent_nxt[i].needA = 1'b0;
            end
            if (wk_hit(r_ent[i].tagB, wk_vld, wk_tag)) begin
                w_ent_nxt[i].needB = 1'b0;
            end
        end
        for (int p = 0; p < NIN; p++) begin
            if (w_ins_do[p]) begin
                s                  = ins_slot[p*SLOTW +: SLOTW];
                w_new[s]           = 1'b1;
                w_rank[s]          = 3'(p);
                w_ent_nxt[s].valid = 1'b1;
                w_ent_nxt[s].needA = ins_needA[p] & ~wk_hit(ins_tagA[p*TAGW +: TAGW], wk_vld, wk_tag);
                w_ent_nxt[s].needB = ins_needB[p] & ~wk_hit(ins_tagB[p*TAGW +: TAGW], wk_vld, wk_tag);
                w_ent_nxt[s].tagA  = ins_tagA[p*TAGW +: TAGW];
                w_ent_nxt[s].tagB  = ins_tagB[p*TAGW +: TAGW];
                w_ent_nxt[s].port  = ins_port[p*NOUT +: NOUT];
                w_ent_nxt[s].thread = ins_thread[p];
            end
        end
        // New entries are younger than all residents; among themselves lower port is older.
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i == j) begin
                    w_age_nxt[i][j] = 1'b0;
                end else if (w_new[i] && w_new[j]) begin
                    w_age_nxt[i][j] = (w_rank[i] < w_rank[j]);
                end else if (w_new[i]) begin
                    w_age_nxt[i][j] = 1'b0;
                end else if (w_new[j]) begin
                    w_age_nxt[i][j] = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_valid += int'(w_ent_nxt[i].valid);
        end
        w_free_nxt = (SLOTW+1)'(DEPTH - n_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
            end
            r_age        <= '0;
            r_free_cnt   <= (SLOTW+1)'(DEPTH);
            r_can_accept <= 1'b1;
        end else begin
            r_ent        <= w_ent_nxt;
            r_age        <= w_age_nxt;
            r_free_cnt   <= w_free_nxt;
            r_can_accept <= (w_free_nxt >= (SLOTW+1)'(NIN));
        end
    end

endmodule
